// File: rtl/csync_pkg.sv
// csync_pkg: shared pulse classes, decoder states and default sync timing.
// Timing defaults are also used by the gen_sync benches.
package csync_pkg;

   typedef enum logic [2:0] {
      PC_NONE    = 3'd0,
      PC_EQ      = 3'd1,
      PC_HSYNC   = 3'd2,
      PC_BROAD   = 3'd3,
      PC_INVALID = 3'd4
   } pulse_class_t;

   typedef enum logic {
      IDLE_HIGH,
      MEASURE_LOW
   } dec_state_t;

   localparam int DEF_LINE_CLKS  = 766;
   localparam int DEF_TOL        = 8;
   localparam int DEF_GLITCH_MAX = 8;
   localparam int DEF_EQ_MAX     = 40;
   localparam int DEF_HS_MAX     = 80;
   localparam int DEF_BROAD_MIN  = 200;
   localparam int DEF_LOCK_LINES = 4;

   function automatic logic [10:0] sat_inc11(input logic [10:0] v);
      return (&v) ? v : v + 11'd1;
   endfunction

endpackage

// File: rtl/csync_sync_edge.sv
// csync_sync_edge: two-flop synchronizer (idles high) plus registered
// fall/rise pulses taken from the synchronized level.
module csync_sync_edge
   import csync_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic fall,
   output logic rise
);

   // sh[1:0] is the synchronizer, sh[2] the previous synchronized level
   logic [2:0] sh;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh   <= 3'b111;
         fall <= 1'b0;
         rise <= 1'b0;
      end else begin
         sh   <= {sh[1:0], din};
         fall <= sh[2] & ~sh[1];
         rise <= ~sh[2] & sh[1];
      end
   end

endmodule

// File: rtl/csync_decode.sv
// csync_decode: classifies composite-sync pulses by low width and checks
// fall-to-fall spacing to recover hsync strobes, vsync, line count and lock.
module csync_decode
   import csync_pkg::*;
#(
   parameter int LINE_CLKS  = DEF_LINE_CLKS,
   parameter int TOL        = DEF_TOL,
   parameter int GLITCH_MAX = DEF_GLITCH_MAX,
   parameter int EQ_MAX     = DEF_EQ_MAX,
   parameter int HS_MAX     = DEF_HS_MAX,
   parameter int BROAD_MIN  = DEF_BROAD_MIN,
   parameter int LOCK_LINES = DEF_LOCK_LINES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         csync,
   output logic         pulse_stb,
   output pulse_class_t pulse_class,
   output logic         hsync_stb,
   output logic         vsync,
   output logic [8:0]   line_cnt,
   output logic         locked
);

   localparam logic [9:0]  GL_W = 10'(GLITCH_MAX);
   localparam logic [9:0]  EQ_W = 10'(EQ_MAX);
   localparam logic [9:0]  HS_W = 10'(HS_MAX);
   localparam logic [9:0]  BR_W = 10'(BROAD_MIN);
   localparam logic [11:0] LN_P = 12'(LINE_CLKS);
   localparam logic [11:0] HF_P = 12'(LINE_CLKS / 2);
   localparam logic [11:0] TL_P = 12'(TOL);
   localparam logic [10:0] TO_S = 11'(2 * LINE_CLKS);
   localparam logic [2:0]  LK_N = 3'(LOCK_LINES);

   logic         fall;
   logic         rise;
   dec_state_t   state_q;
   dec_state_t   state_d;
   logic [9:0]   width_q;
   logic [10:0]  since_q;
   logic [10:0]  spacing_q;
   logic [10:0]  spc_cand;
   logic [2:0]   good_cnt;
   logic         have_ref;
   pulse_class_t cls;
   logic [11:0]  per;
   logic         full_ok;
   logic         half_ok;
   logic         per_ok;
   logic         accept;
   logic         bad;
   logic         good;
   logic         timeout;

   csync_sync_edge u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (csync),
      .fall  (fall),
      .rise  (rise)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE_HIGH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE_HIGH:   if (fall) state_d = MEASURE_LOW;
         MEASURE_LOW: if (rise) state_d = IDLE_HIGH;
      endcase
   end

   always_comb begin
      cls = PC_INVALID;
      if (width_q <= GL_W)      cls = PC_NONE;
      else if (width_q <= EQ_W) cls = PC_EQ;
      else if (width_q <= HS_W) cls = PC_HSYNC;
      else if (width_q >= BR_W) cls = PC_BROAD;

      per     = {1'b0, spc_cand};
      full_ok = (per + TL_P >= LN_P) && (per <= LN_P + TL_P);
      half_ok = (per + TL_P >= HF_P) && (per <= HF_P + TL_P);
      per_ok  = !have_ref || full_ok
             || (half_ok && cls != PC_HSYNC);

      accept  = rise && state_q == MEASURE_LOW
             && cls != PC_NONE;
      bad     = accept && (cls == PC_INVALID || !per_ok);
      good    = accept && !bad && have_ref
             && cls == PC_HSYNC;
      // a rise restarts spacing, so it wins over a coincident timeout
      timeout = !accept && spacing_q >= TO_S;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         width_q     <= '0;
         since_q     <= '0;
         spacing_q   <= '0;
         spc_cand    <= '0;
         good_cnt    <= '0;
         have_ref    <= 1'b0;
         pulse_stb   <= 1'b0;
         pulse_class <= PC_NONE;
         hsync_stb   <= 1'b0;
         vsync       <= 1'b0;
         line_cnt    <= '0;
         locked      <= 1'b0;
      end else begin
         pulse_stb <= accept;
         hsync_stb <= accept && cls == PC_HSYNC;

         if (fall) begin
            width_q  <= 10'd1;
            since_q  <= 11'd1;
            spc_cand <= spacing_q;
         end else begin
            if (state_q == MEASURE_LOW && !(&width_q))
               width_q <= width_q + 10'd1;
            since_q <= sat_inc11(since_q);
         end

         // spacing only rebases on pulses that survive the glitch filter
         if (accept) spacing_q <= sat_inc11(since_q);
         else        spacing_q <= sat_inc11(spacing_q);

         if (accept) begin
            pulse_class <= cls;
            have_ref    <= 1'b1;
            if (bad) begin
               locked   <= 1'b0;
               good_cnt <= '0;
            end else if (good) begin
               if (good_cnt != LK_N)
                  good_cnt <= good_cnt + 3'd1;
               if (good_cnt >= LK_N - 3'd1)
                  locked <= 1'b1;
            end
            if (cls == PC_BROAD)
               vsync <= 1'b1;
            else if (cls != PC_INVALID)
               vsync <= 1'b0;
            if (vsync && (cls == PC_EQ || cls == PC_HSYNC))
               line_cnt <= '0;
            else if (cls == PC_HSYNC && !(&line_cnt))
               line_cnt <= line_cnt + 9'd1;
         end else if (timeout) begin
            locked   <= 1'b0;
            good_cnt <= '0;
            have_ref <= 1'b0;
            vsync    <= 1'b0;
            if (vsync) line_cnt <= '0;
         end
      end
   end

endmodule

// File: doc/csync_decode.md
# csync_decode

Composite-sync decoder: samples an active-low composite sync line (the `csync` produced by `gen_sync`, or a real video source) and recovers a horizontal strobe, a vertical sync level, a line count and a lock flag. It is the receive end of the csync path. It sits in the capture/verification side of the design, clocked by the same `clk` domain as `gen_sync`. It classifies every sync pulse by its low width and checks falling-edge spacing against the nominal line period.

## Interface
- `LINE_CLKS`, 766: nominal clocks per line.
- `TOL`, 8: allowed ± deviation on fall-to-fall spacing.
- `GLITCH_MAX`, 8: low pulses of width ≤ this are ignored.
- `EQ_MAX`, 40: widths in (GLITCH_MAX, EQ_MAX] classify as equalizing.
- `HS_MAX`, 80: widths in (EQ_MAX, HS_MAX] classify as hsync.
- `BROAD_MIN`, 200: widths ≥ this classify as broad (vertical) pulses. Widths in (HS_MAX, BROAD_MIN) are invalid.
- `LOCK_LINES`, 4: consecutive good hsync spacings required to lock.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `csync` in 1: composite sync input, asynchronous, active low.
- `pulse_stb` out 1: one-cycle strobe, asserted once per accepted pulse.
- `pulse_class` out 3: class of the last accepted pulse (`csync_pkg` enum). Held between strobes.
- `hsync_stb` out 1: one-cycle strobe for hsync-class pulses only.
- `vsync` out 1: active-high vertical sync level.
- `line_cnt` out 9: lines since end of vsync. Saturates at 511.
- `locked` out 1: timing lock.

## Operation
- Synchronizer: 2 flops, reset value 1, so that reset never produces a spurious falling edge. Edge detection is done on the synchronized signal.
- States: `IDLE_HIGH` → (fall) → `MEASURE_LOW` → (rise) → classify → `IDLE_HIGH`.
- `width`: 10 bits. Counts low cycles of the synchronized signal. Saturates at 1023; a saturated width still classifies as broad.
- `spacing`: 11 bits, counting clocks since the last accepted fall. Saturates at 2047.
  - At each fall, spacing is latched into `spc_cand`.
  - On an accepted rise, `spc_cand` becomes the period of that pulse.
  - Glitch pulses do not disturb spacing.
- Classification happens at the rise, per the parameter bands. Glitches produce no strobe and no state change.
- Period check, per class:
  - Hsync must have period LINE_CLKS ± TOL.
  - Equalizing and broad pulses accept either LINE_CLKS ± TOL or LINE_CLKS/2 ± TOL.
  - The first accepted pulse after reset or timeout has no period check.
- Lock:
  - `good_cnt` increments on each hsync with a good period.
  - `locked` sets when `good_cnt` reaches LOCK_LINES.
  - A period error, an invalid pulse, or spacing reaching 2·LINE_CLKS clears `locked` and `good_cnt`. The spacing condition is the timeout.
- Vsync:
  - Set on the first accepted broad pulse.
  - Cleared on the first accepted non-broad, non-invalid pulse after it.
  - Also cleared on timeout.
- Line count:
  - `line_cnt` resets to 0 on the cycle `vsync` falls.
  - Increments on each `hsync_stb`.
  - Equalizing pulses do not count.
- Simultaneous events: when timeout and an accepted rise occur in the same cycle, the rise is processed and timeout is ignored, because the spacing restarts.
- Reset mid-pulse: all state is discarded. The next fall starts a fresh measurement.

## Timing
- Reset values: `pulse_stb`=0, `pulse_class`=PC_NONE, `hsync_stb`=0, `vsync`=0, `line_cnt`=0, `locked`=0.
- Latency: a `csync` rise sampled at edge N gives `pulse_stb`/`hsync_stb` high for exactly cycle N+3, with `pulse_class` valid from the same cycle.
- `vsync`, `line_cnt` and `locked` update in the same cycle as the strobe.
- `vsync` falling and `line_cnt` clearing occur in the same cycle.
- The width reported equals the `csync` low time in clocks. Measurement is exact because both edges see the same synchronizer delay.

## Structure
- Package `csync_pkg` holds:
  - `pulse_class_t` enum: PC_NONE, PC_EQ, PC_HSYNC, PC_BROAD, PC_INVALID.
  - Default timing constants, shared with `gen_sync` benches.
- Sub-module `csync_sync_edge` contains the 2-flop synchronizer (reset to 1) and produces `fall`/`rise` pulses.
- Everything else lives in `csync_decode`.

## Test plan
- Reset, then `csync`=1 held for 3000 clk → all outputs stay at their reset values. `locked` stays 0 and no strobe appears.
- Hsync train, 56-clk low every 766 clk, 6 lines:
  - 6 `hsync_stb`, each 3 cycles after its rise, with `pulse_class`=PC_HSYNC.
  - `locked` rises on the 5th strobe (first pulse unchecked, then 4 good periods).
- Full field from `gen_sync` (`vsync` 0 for 3 lines):
  - `vsync` rises at the first broad strobe and falls at the first equalizing strobe after it.
  - `line_cnt` goes 0→1 at the next hsync.
  - `locked` stays 1 throughout.
- Locked train with one line at 790 clk → `locked` clears on that strobe and relocks 4 good lines later.
- Inject a 5-clk low glitch mid-line → no strobe, lock kept, the next hsync period is still 766. A 120-clk pulse → PC_INVALID and `locked`=0.
- Remove `csync` pulses (hold high) while locked → `locked` and `vsync` clear at spacing 1532. Assert `rst_n`=0 mid broad pulse → outputs return to reset values on the next edge.
